mem_bist: RTL
=============

# mem_bist

Built-in self-test sequencer that sits directly upstream of the 8-bit synchronous single-port memory and drives its data/address and control (en, rw) lines. On `start` it runs a two-pass pattern test: write, read-back compare, then inverted write and read-back compare. It stops on the first mismatch and reports pass/fail plus the failing address and data. It replaces the hand-driven test stimulus on the memory's control bus.

## Interface
- `AW`, 8: address width.
- `DW`, 8: data width.
- `ADDR_LAST`, 254: highest address tested. The range is 0..ADDR_LAST, and N = ADDR_LAST+1.
- `PATTERN`, 8'hA5: base data pattern, DW bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a test run; sampled on the rising edge of `clk`.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high once a run has finished; held until the next accepted start.
- `pass`  out  1  valid when `done`=1; 1 = no mismatch.
- `fail_addr`  out  AW  address of the first mismatch; 0 if the run passed.
- `fail_data`  out  DW  data read at `fail_addr`; 0 if the run passed.
- `mem_en`  out  1  memory enable.
- `mem_rw`  out  1  1 = write, 0 = read.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  write data.
- `mem_rdata`  in  DW  memory read data. The memory registers it on the edge where `mem_en`=1 and `mem_rw`=0.

## Operation
- Expected data: `exp0(a)` = PATTERN ^ a[DW-1:0]; `exp1(a)` = ~exp0(a).
- Addresses increment by 1 from 0 to ADDR_LAST inclusive, with no wrap past ADDR_LAST.
- FSM states:
  - IDLE: `start`=1 -> clear `done`/`pass`/`fail_*`, `busy`=1, address=0 -> WR0.
  - WR0: `mem_en`=1, `mem_rw`=1, `mem_wdata`=exp0(a). If a==ADDR_LAST, set a=0 -> RD0_ISS; otherwise a++.
  - RD0_ISS: `mem_en`=1, `mem_rw`=0, `mem_addr`=a -> RD0_CHK.
  - RD0_CHK: `mem_en`=0. Compare `mem_rdata` with exp0(a).
    - Mismatch: capture a into `fail_addr` and `mem_rdata` into `fail_data`; `pass`=0 -> DONE.
    - Match, a==ADDR_LAST: a=0 -> WR1.
    - Match, otherwise: a++ -> RD0_ISS.
  - WR1, RD1_ISS, RD1_CHK: same as the 0-pass using exp1. A match at ADDR_LAST sets `pass`=1 -> DONE.
  - DONE: `busy`=0, `done`=1. `start`=1 -> same action as in IDLE.
- `start` is ignored while `busy`=1.
- Outside WR*/RD*_ISS: `mem_en`=0, `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0.
- All outputs are registered, with no combinational path from inputs.

## Timing
- Reset (async assert): every output is 0, FSM in IDLE, address counter 0.
  - Reset asserted mid-run aborts immediately; `mem_en` drops without waiting for a clock.
  - No result is reported, and memory contents are undefined afterward.
- Deassertion is synchronous to `clk` in the integration; the first `start` is honored on the first edge after release.
- Start accepted at edge E0:
  - `busy`=1 and the first write (addr 0) are visible in the cycle after E0.
  - One write per cycle; each read takes 2 cycles (issue, check).
- Passing run:
  - `done`=1, `pass`=1, `busy`=0 after edge E0+6N (1530 cycles at defaults).
- Failing run at pass p, address f:
  - `done` rises at edge E0 + N + 2(f+1) for p=0.
  - `done` rises at edge E0 + 4N + 2(f+1) for p=1.
- `mem_rdata` is sampled on the edge ending the RD*_CHK cycle, i.e. one cycle after the issue edge.
- `start` held high in DONE restarts a run on that edge, giving back-to-back runs.

## Test plan
- Fault-free memory model, defaults, `start` pulsed at E0 -> full bus sequence; `done`=1 and `pass`=1 at E0+1530; `fail_addr`=0 and `fail_data`=0.
- Bit 3 of address 0x10 stuck-at-1 -> `done` at E0+289, `pass`=0, `fail_addr`=0x10, `fail_data`=0xBD (expected 0xB5).
- ADDR_LAST=3 -> exact trace:
  - Writes of A5, A4, A7, A6 to addresses 0..3.
  - Reads of 0..3 with `mem_en` alternating 1/0.
  - Writes of 5A, 5B, 58, 59.
  - Reads, then `done` at E0+24.
- `start` pulsed at cycles 5 and 100 of a run -> both ignored; completion time unchanged.
- `rst_n` low at cycle 700 -> all outputs 0 immediately. Release, then `start` -> a fresh run passes in 1530 cycles.
- `start` held high through DONE -> second run begins the edge `done` is seen. `done` and `pass` clear, and the second run passes.

Source files
------------

// File: rtl/mem_bist_if.sv
// Memory-side bus between the BIST sequencer and the single-port memory.
// The master drives address/data/control; the slave returns registered read data.
interface mem_bist_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_rw,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_rw,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bist.sv
// Two-pass memory BIST: write pattern, read-compare, write inverted pattern, read-compare.
// Stops on the first mismatch and latches the failing address and read data.
module mem_bist #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   DW        = 8,
  parameter int unsigned   ADDR_LAST = 254,
  parameter logic [DW-1:0] PATTERN   = DW'(8'hA5)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  mem_bist_if.master    mem
);

  typedef enum logic [2:0] {
    StIdle, StWr0, StRd0Iss, StRd0Chk, StWr1, StRd1Iss, StRd1Chk, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic          en_q, en_d, rw_q, rw_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic last, start_ok, mismatch;

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input logic inv);
    logic [DW-1:0] d;
    d = PATTERN ^ DW'(a);
    return inv ? ~d : d;
  endfunction

  assign last     = (addr_q == AW'(ADDR_LAST));
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign mismatch = ((state_q == StRd0Chk) || (state_q == StRd1Chk)) &&
                    (mem.mem_rdata != exp_data(addr_q, state_q == StRd1Chk));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      maddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWr0;
          addr_d  = '0;
        end
      end
      StWr0, StWr1: begin
        if (last) begin
          addr_d  = '0;
          state_d = (state_q == StWr0) ? StRd0Iss : StRd1Iss;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StRd0Iss: state_d = StRd0Chk;
      StRd1Iss: state_d = StRd1Chk;
      StRd0Chk, StRd1Chk: begin
        if (mismatch) begin
          state_d = StDone;
        end else if (last) begin
          addr_d  = '0;
          state_d = (state_q == StRd0Chk) ? StWr1 : StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = (state_q == StRd0Chk) ? StRd0Iss : StRd1Iss;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so the registered bus lines up with it.
  always_comb begin
    en_d        = 1'b0;
    rw_d        = 1'b0;
    maddr_d     = '0;
    wdata_d     = '0;
    busy_d      = (state_d != StIdle) && (state_d != StDone);
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    unique case (state_d)
      StWr0, StWr1: begin
        en_d    = 1'b1;
        rw_d    = 1'b1;
        maddr_d = addr_d;
        wdata_d = exp_data(addr_d, state_d == StWr1);
      end
      StRd0Iss, StRd1Iss: begin
        en_d    = 1'b1;
        maddr_d = addr_d;
      end
      default: ;
    endcase

    if (start_ok) begin
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (mismatch) begin
      done_d      = 1'b1;
      pass_d      = 1'b0;
      fail_addr_d = addr_q;
      fail_data_d = mem.mem_rdata;
    end else if ((state_q == StRd1Chk) && last) begin
      done_d = 1'b1;
      pass_d = 1'b1;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_addr     = fail_addr_q;
  assign fail_data     = fail_data_q;
  assign mem.mem_en    = en_q;
  assign mem.mem_rw    = rw_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
